// File: rtl/bcd_scan_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_scan_sequencer
//
// Time-multiplexes a 4-digit BCD word onto a single BCD bus with one-hot digit
// enables. Each digit is driven for SCAN_DIV clocks and followed by one blank
// cycle, so a full frame lasts 4*(SCAN_DIV+1) clocks. New words enter through
// a one-deep shadow buffer and are copied into the active register only when
// scanning starts or at a frame boundary, so a frame never shows a mix of
// two words. Digits above 9 are blanked on the display and raise a sticky
// error flag.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   i_scan_en       1 = scan digits, 0 = return to idle
//   i_load_valid    a new word is offered on i_load_data
//   i_load_data     four BCD digits, digit 0 in bits [3:0]
//   o_load_ready    shadow buffer is empty and can accept a word
//   i_clear_err     clears o_invalid_digit on the next edge
//   o_bcd_out       digit value for the downstream decoder
//   o_digit_sel     one-hot digit enable, bit i = digit i
//   o_out_valid     o_bcd_out / o_digit_sel are meaningful
//   o_frame_done    high during the blank cycle after digit 3
//   o_invalid_digit sticky: a digit greater than 9 was scanned
// ---------------------------------------------------------------------------
module bcd_scan_sequencer #(
  parameter int unsigned SCAN_DIV = 4  // clocks per digit, 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_scan_en,
  input  logic        i_load_valid,
  input  logic [15:0] i_load_data,
  output logic        o_load_ready,
  input  logic        i_clear_err,
  output logic [3:0]  o_bcd_out,
  output logic [3:0]  o_digit_sel,
  output logic        o_out_valid,
  output logic        o_frame_done,
  output logic        o_invalid_digit
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(SCAN_DIV - 1);

  // Registered state
  state_t      r_state;
  logic [1:0]  r_index;
  logic [7:0]  r_count;
  logic [15:0] r_active;
  logic [15:0] r_shadow;
  logic        r_pending;
  logic        r_invalid;

  // Next-state values
  state_t      w_state;
  logic [1:0]  w_index;
  logic [7:0]  w_count;
  logic [15:0] w_active;
  logic [15:0] w_shadow;
  logic        w_pending;
  logic        w_invalid;

  logic        w_xfer;       // shadow -> active copy on this edge
  logic        w_load;       // shadow accepts i_load_data on this edge
  logic [3:0]  w_digit;      // active digit addressed by r_index
  logic        w_digit_bad;  // DRIVE cycle showing a non-BCD digit

  assign w_digit     = r_active[{r_index, 2'b00} +: 4];
  assign w_digit_bad = (r_state == ST_DRIVE) && (w_digit > 4'd9);
  assign w_load      = i_load_valid && !r_pending;

  // Next-state logic
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state   = r_state;
    w_index   = r_index;
    w_count   = r_count;
    w_active  = r_active;
    w_shadow  = r_shadow;
    w_pending = r_pending;
    w_xfer    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_scan_en) begin
          w_state = ST_DRIVE;
          w_index = 2'd0;
          w_count = 8'd0;
          w_xfer  = r_pending;
        end
      end

      ST_DRIVE: begin
        if (!i_scan_en) begin
          w_state = ST_IDLE;
          w_index = 2'd0;
          w_count = 8'd0;
        end else if (r_count == DWELL_LAST) begin
          w_state = ST_BLANK;
          w_count = 8'd0;
        end else begin
          w_count = r_count + 8'd1;
        end
      end

      ST_BLANK: begin
        if (!i_scan_en) begin
          w_state = ST_IDLE;
          w_index = 2'd0;
          w_count = 8'd0;
        end else begin
          w_state = ST_DRIVE;
          // Index 3 wraps to 0 here; that edge is the frame boundary.
          w_index = r_index + 2'd1;
          w_xfer  = (r_index == 2'd3) && r_pending;
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_index = 2'd0;
        w_count = 8'd0;
      end
    endcase

    // A transfer only happens while pending, when o_load_ready is low, so it
    // can never coincide with a load.
    if (w_xfer) begin
      w_active  = r_shadow;
      w_pending = 1'b0;
    end else if (w_load) begin
      w_shadow  = i_load_data;
      w_pending = 1'b1;
    end

    // Setting takes priority over a simultaneous clear.
    w_invalid = w_digit_bad || (r_invalid && !i_clear_err);
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_index   <= 2'd0;
      r_count   <= 8'd0;
      r_active  <= 16'h0000;
      r_shadow  <= 16'h0000;
      r_pending <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_index   <= w_index;
      r_count   <= w_count;
      r_active  <= w_active;
      r_shadow  <= w_shadow;
      r_pending <= w_pending;
      r_invalid <= w_invalid;
    end
  end

  // Output decode: a function of registered state only, never of inputs.
  always_comb begin
    o_bcd_out       = 4'd0;
    o_digit_sel     = 4'd0;
    o_out_valid     = 1'b0;
    o_frame_done    = (r_state == ST_BLANK) && (r_index == 2'd3);
    o_load_ready    = !r_pending;
    o_invalid_digit = r_invalid;

    if (r_state == ST_DRIVE) begin
      o_bcd_out = w_digit;
      if (w_digit <= 4'd9) begin
        o_digit_sel = 4'b0001 << r_index;
        o_out_valid = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_sequencer
//
// Drives bcd_scan_sequencer (SCAN_DIV = 2) through directed scenarios and a
// random phase. Expected outputs come from a frame-position model: a running
// display sits at position p within a 4*(DIV+1)-cycle frame, digit p/(DIV+1)
// is shown unless p%(DIV+1) == DIV (blank slot). Directed scenarios also
// check fixed expected sequences.
// ---------------------------------------------------------------------------
module tb_bcd_scan_sequencer;

  localparam int DIV   = 2;
  localparam int FRAME = 4 * (DIV + 1);

  logic        clk;
  logic        rst_n;
  logic        scan_en;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        clear_err;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_sel;
  logic        out_valid;
  logic        frame_done;
  logic        invalid_digit;

  bcd_scan_sequencer #(.SCAN_DIV(DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_scan_en       (scan_en),
    .i_load_valid    (load_valid),
    .i_load_data     (load_data),
    .o_load_ready    (load_ready),
    .i_clear_err     (clear_err),
    .o_bcd_out       (bcd_out),
    .o_digit_sel     (digit_sel),
    .o_out_valid     (out_valid),
    .o_frame_done    (frame_done),
    .o_invalid_digit (invalid_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_run;
  int          m_pos;
  logic [15:0] m_act;
  logic [15:0] m_shd;
  bit          m_pend;
  bit          m_inv;

  // Outputs captured at the most recent sample point
  logic [3:0]  s_bcd;
  logic [3:0]  s_sel;
  logic        s_val;
  logic        s_fd;
  logic        s_rdy;
  logic        s_inv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_pos  = 0;
    m_act  = 16'h0000;
    m_shd  = 16'h0000;
    m_pend = 0;
    m_inv  = 0;
  endtask

  // Compare all DUT outputs against the model's view of the current cycle.
  task automatic check_model(input string where);
    int          dig;
    bit          drive;
    logic [3:0]  d;
    logic [3:0]  e_bcd;
    logic [3:0]  e_sel;
    bit          e_val;
    dig   = m_pos / (DIV + 1);
    drive = m_run && ((m_pos % (DIV + 1)) != DIV);
    d     = 4'((m_act >> (4 * dig)) & 16'hF);
    e_bcd = drive ? d : 4'd0;
    e_val = drive && (d <= 4'd9);
    e_sel = e_val ? 4'(1 << dig) : 4'd0;
    s_bcd = bcd_out;
    s_sel = digit_sel;
    s_val = out_valid;
    s_fd  = frame_done;
    s_rdy = load_ready;
    s_inv = invalid_digit;
    check({where, ".bcd"},   32'(s_bcd), 32'(e_bcd));
    check({where, ".sel"},   32'(s_sel), 32'(e_sel));
    check({where, ".valid"}, 32'(s_val), 32'(e_val));
    check({where, ".fdone"}, 32'(s_fd),  32'(m_run && (m_pos == FRAME - 1)));
    check({where, ".ready"}, 32'(s_rdy), 32'(!m_pend));
    check({where, ".inv"},   32'(s_inv), 32'(m_inv));
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input bit se, input bit lv, input logic [15:0] ld, input bit ce);
    int         dig;
    bit         drive;
    bit         xfer;
    logic [3:0] d;
    dig   = m_pos / (DIV + 1);
    drive = m_run && ((m_pos % (DIV + 1)) != DIV);
    d     = 4'((m_act >> (4 * dig)) & 16'hF);
    m_inv = (drive && d > 4'd9) || (m_inv && !ce);
    xfer  = 0;
    if (!m_run) begin
      if (se) begin
        m_run = 1;
        m_pos = 0;
        xfer  = m_pend;
      end
    end else if (!se) begin
      m_run = 0;
      m_pos = 0;
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0;
      xfer  = m_pend;
    end else begin
      m_pos++;
    end
    if (xfer) begin
      m_act  = m_shd;
      m_pend = 0;
    end else if (lv && !m_pend) begin
      m_shd  = ld;
      m_pend = 1;
    end
  endtask

  // One clock: apply inputs after the falling edge, sample, then take the edge.
  task automatic step(input bit se, input bit lv, input logic [15:0] ld, input bit ce,
                      input string where);
    @(negedge clk);
    scan_en    = se;
    load_valid = lv;
    load_data  = ld;
    clear_err  = ce;
    #1;
    check_model(where);
    @(posedge clk);
    model_edge(se, lv, ld, ce);
  endtask

  int seq_4321 [FRAME] = '{1, 1, 0, 2, 2, 0, 3, 3, 0, 4, 4, 0};
  int sel_seq  [FRAME] = '{1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0};
  int seq_9999 [FRAME] = '{9, 9, 0, 9, 9, 0, 9, 9, 0, 9, 9, 0};

  initial begin
    rst_n      = 1'b0;
    scan_en    = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    clear_err  = 1'b0;
    model_reset();

    // Reset state
    #1;
    check_model("reset");
    #1 rst_n = 1'b1;

    // Basic scan
    step(0, 1, 16'h4321, 0, "load4321");
    step(1, 0, 16'h0000, 0, "enable");
    for (int i = 0; i < FRAME; i++) begin
      step(1, 0, 16'h0000, 0, "basic");
      check("basic_seq_bcd", 32'(s_bcd), 32'(seq_4321[i]));
      check("basic_seq_sel", 32'(s_sel), 32'(sel_seq[i]));
      check("basic_seq_fd",  32'(s_fd),  32'(i == FRAME - 1));
    end

    // Double buffer plus overwrite guard within the same frame
    for (int i = 0; i < FRAME; i++) begin
      if (i == 4)      step(1, 1, 16'h9999, 0, "dbuf");
      else if (i == 7) step(1, 1, 16'h5555, 0, "guard");
      else             step(1, 0, 16'h0000, 0, "dbuf");
      check("dbuf_cur_bcd", 32'(s_bcd), 32'(seq_4321[i]));
      check("dbuf_ready",   32'(s_rdy), 32'(i <= 4));
    end
    for (int i = 0; i < FRAME; i++) begin
      if (i == 1) step(1, 1, 16'h0A00, 0, "next9999");
      else        step(1, 0, 16'h0000, 0, "next9999");
      check("next_bcd", 32'(s_bcd), 32'(seq_9999[i]));
      if (i <= 1) check("next_ready", 32'(s_rdy), 32'd1);
    end

    // Invalid digit: first frame with 0A00, flag goes sticky
    for (int i = 0; i < FRAME; i++) begin
      step(1, 0, 16'h0000, 0, "inv");
      if (i == 6 || i == 7) begin
        check("inv_slot_sel",   32'(s_sel), 32'd0);
        check("inv_slot_valid", 32'(s_val), 32'd0);
      end
      check("inv_flag", 32'(s_inv), 32'(i >= 7));
    end
    // Clear in digit-0 slot, then clear coincident with digit-2 DRIVE
    for (int i = 0; i < FRAME; i++) begin
      step(1, 0, 16'h0000, (i == 0 || i == 7), "clr");
      if (i == 0)           check("clr_before", 32'(s_inv), 32'd1);
      if (i >= 1 && i <= 6) check("clr_cleared", 32'(s_inv), 32'd0);
      if (i >= 7)           check("clr_setwins", 32'(s_inv), 32'd1);
    end

    // Abort during digit 2, then restart at digit 0
    step(1, 1, 16'h4321, 1, "abort_load");
    for (int i = 1; i < FRAME; i++) step(1, 0, 16'h0000, 0, "abort_pre");
    for (int i = 0; i < 6; i++) step(1, 0, 16'h0000, 0, "abort_pre2");
    step(0, 0, 16'h0000, 0, "abort");
    check("abort_was_d2", 32'(s_sel), 32'h4);
    step(0, 0, 16'h0000, 0, "abort_idle");
    check("abort_idle_sel", 32'(s_sel), 32'd0);
    check("abort_idle_fd",  32'(s_fd),  32'd0);
    step(1, 0, 16'h0000, 0, "reenable");
    step(1, 0, 16'h0000, 0, "restart");
    check("restart_sel", 32'(s_sel), 32'h1);
    check("restart_bcd", 32'(s_bcd), 32'h1);

    // Reset mid-frame with a pending word
    step(1, 1, 16'h8765, 0, "rst_load");
    step(1, 0, 16'h0000, 0, "rst_pend");
    check("rst_pend_ready", 32'(s_rdy), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("rst_async");
    #1 rst_n = 1'b1;
    step(0, 0, 16'h0000, 0, "post_rst");
    step(1, 0, 16'h0000, 0, "post_rst_en");
    for (int i = 0; i < FRAME; i++) begin
      step(1, 0, 16'h0000, 0, "post_rst_scan");
      check("post_rst_no_old", 32'(s_bcd), 32'd0);
    end

    // Random phase against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 16) != 0, ($urandom % 4) == 0, 16'($urandom),
           ($urandom % 8) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_sequencer.md
BCD_SCAN_SEQUENCER -- requirements
Module: bcd_scan_sequencer

Interface
REQ-001 Parameter SCAN_DIV, default 4: number of clocks each digit is driven; legal range 1..255.
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Scan_En  input  1  run request; 1 = scan digits, 0 = return to idle.
REQ-005 Load_Valid  input  1  a new 4-digit word is offered.
REQ-006 Load_Data  input  16  four BCD digits; digit i = Load_Data[4i+3:4i], digit 0 is least significant.
REQ-007 Load_Ready  output  1  the shadow buffer can accept a word.
REQ-008 Clear_Err  input  1  clears Invalid_Digit.
REQ-009 BCD_Out  output  4  digit value to the downstream BCD-to-decimal decoder.
REQ-010 Digit_Sel  output  4  one-hot digit enable; bit i = digit i.
REQ-011 Out_Valid  output  1  BCD_Out and Digit_Sel are meaningful.
REQ-012 Frame_Done  output  1  one-cycle pulse at the end of each complete 4-digit frame.
REQ-013 Invalid_Digit  output  1  sticky flag; a digit greater than 9 was scanned.

Function
REQ-014 All outputs SHALL be decoded from registered state only, with no combinational path from any input to any output.
REQ-015 Storage SHALL be a 16-bit shadow register, a Pending flag and a 16-bit active register.
- Load_Ready = !Pending.
- On an edge where Load_Valid && Load_Ready: shadow <= Load_Data and Pending <= 1.
REQ-016 The FSM SHALL have three states: IDLE, DRIVE and BLANK. It also keeps a 2-bit digit index and an 8-bit dwell counter.
REQ-017 IDLE behaviour:
- If Scan_En=1, go to DRIVE with index=0 and counter=0.
- If Pending=1 on that same edge, active <= shadow and Pending <= 0.
REQ-018 DRIVE behaviour:
- The counter increments every cycle.
- When counter = SCAN_DIV-1: go to BLANK and clear the counter.
REQ-019 BLANK lasts exactly 1 cycle, then:
- If index<3: return to DRIVE with index+1.
- If index=3: return to DRIVE with index=0. If Pending=1 on that edge, active <= shadow and Pending <= 0.
REQ-020 One frame SHALL take exactly 4*(SCAN_DIV+1) cycles.
REQ-021 The active register SHALL change only at frame boundaries or on leaving IDLE, never mid-frame.
REQ-022 Frame_Done SHALL be 1 exactly during the BLANK cycle that follows digit 3, and 0 otherwise.
REQ-023 In DRIVE, with d = active digit[index]:
- BCD_Out = d.
- If d<=9: Digit_Sel = one-hot(index) and Out_Valid = 1.
- If d>9: Digit_Sel = 0 and Out_Valid = 0 (the digit is blanked).
REQ-024 In IDLE and BLANK: BCD_Out=0, Digit_Sel=0 and Out_Valid=0.
REQ-025 Invalid_Digit SHALL be set on any edge where the state is DRIVE and the active digit is greater than 9.
- Clear_Err=1 clears it on the next edge.
- If set and clear occur on the same edge, set wins.
REQ-026 Scan_En=0 in DRIVE or BLANK SHALL force IDLE on the next edge.
- Index and counter reset to 0.
- Frame_Done is not asserted.
- Pending and shadow are kept.
REQ-027 When Pending=1, Load_Valid SHALL be ignored (no overwrite); the word is held until the next transfer.
REQ-028 On a transfer edge, Load_Ready is 0, so a load and a transfer SHALL never occur on the same edge. A load accepted in the cycle after a transfer becomes Pending for the following frame.

Reset
REQ-029 When Rst_n=0, the block SHALL immediately enter IDLE, independent of Clk, with all of the following cleared:
- index=0, counter=0
- active=0, shadow=0, Pending=0
- BCD_Out=0, Digit_Sel=0, Out_Valid=0, Frame_Done=0, Invalid_Digit=0
- Load_Ready=1
REQ-030 Rst_n asserted mid-frame SHALL discard any Pending word. Scanning SHALL resume only after Rst_n=1 and Scan_En=1.

Verification
REQ-031 Run all scenarios below with SCAN_DIV=2.
- Basic scan: load 16'h4321, then Scan_En=1. Required: BCD_Out sequence 1,1,-,2,2,-,3,3,-,4,4,- (- = blank cycle); Digit_Sel 0001,0010,0100,1000; Frame_Done pulses every 12 cycles.
- Double buffer: load 16'h9999 mid-frame, while 16'h4321 is active. Required: Load_Ready=0 next cycle; the current frame completes with 4321; the next frame shows 9999; Load_Ready returns to 1 after the transfer.
- Overwrite guard: a second Load_Valid with 16'h5555 while Pending=1. Required: ignored; 9999 is displayed.
- Invalid digit: load 16'h0A00. Required: the digit-2 slot has Out_Valid=0 and Digit_Sel=0; Invalid_Digit=1 and remains 1; Clear_Err in a non-digit-2 cycle clears it; Clear_Err coincident with a digit-2 DRIVE cycle leaves it 1.
- Abort: Scan_En=0 during digit 2. Required: IDLE next cycle with no Frame_Done; re-enable restarts at digit 0.
- Reset mid-frame, with Pending=1: required: all outputs at reset values immediately; Load_Ready=1; the old Pending word is never displayed.
